// File: rtl/board_arb_pkg.sv
// Shared types and constants for the board RAM arbiter.
package board_arb_pkg;

   // Access sequencing: idle, RAM enabled, acknowledge/re-arbitrate.
   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StResp
   } arb_state_e;

   // Owner encoding, also exported on the debug/LED pins.
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CPU  = 2'd1;
   localparam logic [1:0] OWN_DISP = 2'd2;

   localparam int unsigned DEF_ADDR_W = 12;
   localparam int unsigned DEF_DATA_W = 32;

endpackage

// File: rtl/board_mem_arbiter_if.sv
// Bundle of the processor, display-scanner and RAM buses around the arbiter.
interface board_mem_arbiter_if
   import board_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) ();

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;

   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_ack;
   logic [DATA_W-1:0] disp_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter side.
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  disp_req, disp_addr,
      input  mem_rdata,
      output cpu_ack, cpu_rdata,
      output disp_ack, disp_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   // Requester/RAM side.
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output disp_req, disp_addr,
      output mem_rdata,
      input  cpu_ack, cpu_rdata,
      input  disp_ack, disp_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/starve_counter.sv
// Saturating count of cycles the display has been kept waiting.
module starve_counter #(
   parameter int unsigned LIMIT = 8,
   parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             at_limit
);

   logic [CNT_W-1:0] count_q;

   assign at_limit = (count_q == CNT_W'(LIMIT));
   assign count    = count_q;

   // Clear wins over increment; hold once the limit is reached.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (inc && !at_limit) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/board_mem_arbiter.sv
// Two-requester arbiter for the single-port board RAM: the processor has fixed
// priority, the display scanner is protected by a starvation counter.
module board_mem_arbiter
   import board_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                clock,
   input  logic                reset,
   board_mem_arbiter_if.slave  bus,
   output logic [1:0]          owner
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   arb_state_e        state_q;
   logic [1:0]        owner_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              acc_we_q;
   logic              cpu_ack_q;
   logic              disp_ack_q;

   logic [CNT_W-1:0]  wait_cnt;
   logic              at_limit;
   logic              arb_slot;
   logic              cpu_elig;
   logic              disp_elig;
   logic              grant_cpu;
   logic              grant_disp;
   logic              wait_clr;
   logic              wait_inc;

   // Grant decision; the requester being acked in RESP sits out this round.
   always_comb begin
      arb_slot   = (state_q == StIdle) || (state_q == StResp);
      cpu_elig   = bus.cpu_req && !((state_q == StResp) && (owner_q == OWN_CPU));
      disp_elig  = bus.disp_req && !((state_q == StResp) && (owner_q == OWN_DISP));
      grant_disp = arb_slot && disp_elig && (at_limit || !cpu_elig);
      grant_cpu  = arb_slot && cpu_elig && !grant_disp;
      wait_clr   = grant_disp || !bus.disp_req;
      wait_inc   = bus.disp_req && (owner_q != OWN_DISP);
   end

   starve_counter #(
      .LIMIT (STARVE_LIMIT),
      .CNT_W (CNT_W)
   ) u_starve (
      .clock    (clock),
      .reset    (reset),
      .clr      (wait_clr),
      .inc      (wait_inc),
      .count    (wait_cnt),
      .at_limit (at_limit)
   );

   // Sequencer with registered RAM controls, owner and ack pulses.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         owner_q     <= OWN_NONE;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         acc_we_q    <= 1'b0;
         cpu_ack_q   <= 1'b0;
         disp_ack_q  <= 1'b0;
      end else begin
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         cpu_ack_q  <= 1'b0;
         disp_ack_q <= 1'b0;
         case (state_q)
            StAccess: begin
               state_q <= StResp;
               if (owner_q == OWN_CPU) begin
                  cpu_ack_q <= 1'b1;
               end else if (owner_q == OWN_DISP) begin
                  disp_ack_q <= 1'b1;
               end
            end
            StIdle, StResp: begin
               if (grant_disp) begin
                  state_q    <= StAccess;
                  owner_q    <= OWN_DISP;
                  mem_en_q   <= 1'b1;
                  acc_we_q   <= 1'b0;
                  mem_addr_q <= bus.disp_addr;
               end else if (grant_cpu) begin
                  state_q     <= StAccess;
                  owner_q     <= OWN_CPU;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= bus.cpu_we;
                  acc_we_q    <= bus.cpu_we;
                  mem_addr_q  <= bus.cpu_addr;
                  mem_wdata_q <= bus.cpu_wdata;
               end else begin
                  state_q <= StIdle;
                  owner_q <= OWN_NONE;
               end
            end
            default: begin
               state_q <= StIdle;
               owner_q <= OWN_NONE;
            end
         endcase
      end
   end

   // RAM data arrives during RESP, so read data is steered straight through.
   always_comb begin
      bus.cpu_rdata  = (cpu_ack_q && !acc_we_q) ? bus.mem_rdata : '0;
      bus.disp_rdata = disp_ack_q ? bus.mem_rdata : '0;
   end

   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.disp_ack  = disp_ack_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign owner         = owner_q;

endmodule
